// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with debounce.
// Drives one row low at a time, samples the columns on the falling edge of
// slow_clock, debounces press and release, and issues a 4-bit key code with
// a one-cycle KEY_VALID strobe.
// Optional feature macro: KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
module keypad_scanner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_RATE     = 8
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [3:0] KEY,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);

`ifdef KEYPAD_REPEAT_EN
    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAXC   = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
`else
    localparam int MAXC   = DEBOUNCE_CYCLES;
`endif
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DEB_N = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic [CW-1:0] cnt;

    logic [1:0]    row_next;
    logic [1:0]    hit_col;
    logic          lat_low;
    logic [CW-1:0] deb_inc;
    logic          deb_done;
    logic          rep_fire;

    // Lowest-index low column wins; watched column is the latched one only.
    always_comb begin
        hit_col = 2'd0;
        casez (COL)
            4'b???0: hit_col = 2'd0;
            4'b??01: hit_col = 2'd1;
            4'b?011: hit_col = 2'd2;
            4'b0111: hit_col = 2'd3;
            default: hit_col = 2'd0;
        endcase
        row_next = row_idx + 2'd1;
        lat_low  = ~COL[col_idx];
        deb_inc  = (cnt == {CW{1'b1}}) ? cnt : cnt + ONE;
        deb_done = (deb_inc >= DEB_N);
    end

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CW-1:0] REP_DELAY = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] REP_RATE  = CW'(REPEAT_RATE);

    logic [CW-1:0] rep_cnt;
    logic          rep_phase;   // 0: waiting for first repeat, 1: periodic
    logic [CW-1:0] rep_inc;

    // Repeat fires on the hold cycle that completes the current interval.
    always_comb begin
        rep_inc  = (rep_cnt == {CW{1'b1}}) ? rep_cnt : rep_cnt + ONE;
        rep_fire = (state == HELD) && lat_low &&
                   (rep_inc == (rep_phase ? REP_RATE : REP_DELAY));
    end

    // Repeat counter only runs in HELD; any exit (incl. bounce) restarts it.
    always_ff @(negedge slow_clock or negedge reset) begin
        if (!reset) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (state != HELD) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
        end else if (lat_low) begin
            rep_cnt   <= rep_inc;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Scan/debounce FSM with registered row drive and key outputs.
    always_ff @(negedge slow_clock or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            cnt       <= '0;
            ROW       <= 4'b1110;
            KEY       <= 4'd0;
            KEY_VALID <= 1'b0;
            KEY_HELD  <= 1'b0;
        end else begin
            KEY_VALID <= 1'b0;
            case (state)
                SCAN: begin
                    if (COL == 4'b1111) begin
                        row_idx <= row_next;
                        ROW     <= ~(4'b0001 << row_next);
                    end else begin
                        col_idx <= hit_col;
                        cnt     <= ONE;
                        state   <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!lat_low) begin
                        state <= SCAN;          // bounce: rescan same row
                    end else if (deb_done) begin
                        KEY       <= {row_idx, col_idx};
                        KEY_VALID <= 1'b1;
                        KEY_HELD  <= 1'b1;
                        state     <= HELD;
                    end else begin
                        cnt <= deb_inc;
                    end
                end
                HELD: begin
                    if (!lat_low) begin
                        cnt   <= ONE;
                        state <= RELEASE;
                    end else if (rep_fire) begin
                        KEY_VALID <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (lat_low) begin
                        state <= HELD;          // release bounce, no new strobe
                    end else if (deb_done) begin
                        KEY_HELD <= 1'b0;
                        state    <= SCAN;
                        row_idx  <= row_next;
                        ROW      <= ~(4'b0001 << row_next);
                    end else begin
                        cnt <= deb_inc;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner
// (DEBOUNCE_CYCLES=4). A keypad model pulls a column low when its key is
// pressed and its row is driven low. Repeat checks follow KEYPAD_REPEAT_EN.
module tb_keypad_scanner;
    logic       slow_clock = 1'b1;
    logic       reset      = 1'b1;
    logic [3:0] COL;
    logic [3:0] ROW;
    logic [3:0] KEY;
    logic       KEY_VALID;
    logic       KEY_HELD;
    logic [15:0] pressed = 16'h0000;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;
    int doubles = 0;
    int cyc     = 0;
    logic prev_valid = 1'b0;
    int stamp[$];

    keypad_scanner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (32),
        .REPEAT_RATE    (8)
    ) dut (
        .slow_clock(slow_clock),
        .reset     (reset),
        .COL       (COL),
        .ROW       (ROW),
        .KEY       (KEY),
        .KEY_VALID (KEY_VALID),
        .KEY_HELD  (KEY_HELD)
    );

    always #5 slow_clock = ~slow_clock;

    // Keypad matrix: a pressed key shorts its column to its driven-low row.
    always_comb begin
        COL = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!ROW[r] && pressed[r*4+c]) COL[c] = 1'b0;
    end

    // Strobe monitor: count strobes, time-stamp them, flag back-to-back strobes.
    always @(posedge slow_clock) begin
        cyc = cyc + 1;
        if (KEY_VALID === 1'b1) begin
            strobes = strobes + 1;
            stamp.push_back(cyc);
            if (prev_valid === 1'b1) doubles = doubles + 1;
        end
        prev_valid = KEY_VALID;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge slow_clock);
            #1;
        end
    endtask

    task automatic wait_row(input logic [3:0] target);
        int k = 0;
        while (ROW !== target && k < 20) begin
            step(1);
            k++;
        end
        chk("wait_row", {28'd0, ROW}, {28'd0, target});
    endtask

    task automatic wait_strobe(input int s0, input int limit);
        int k = 0;
        while (strobes <= s0 && k < limit) begin
            step(1);
            k++;
        end
        chk("strobe_timeout", 32'(strobes > s0), 32'd1);
    endtask

    initial begin
        int s0;
        int s1;
        int n0;
        int nrep;
        logic [3:0] seq [4];
        seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;

        // 1. reset values and idle row rotation
        #2 reset = 1'b0;
        #1;
        chk("rst_row",   ROW,       4'b1110);
        chk("rst_key",   KEY,       4'h0);
        chk("rst_valid", KEY_VALID, 1'b0);
        chk("rst_held",  KEY_HELD,  1'b0);
        step(2);
        chk("rst_row_hold", ROW, 4'b1110);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("idle_row", ROW, seq[i]);
        end

        // 2. key 6 held 20 cycles: one strobe after 4 samples, release debounce
        wait_row(4'b1101);
        pressed[6] = 1'b1;
        s0 = strobes;
        step(3);
        chk("k6_early_valid", KEY_VALID, 1'b0);
        step(1);
        chk("k6_valid", KEY_VALID, 1'b1);
        chk("k6_key",   KEY,       4'h6);
        chk("k6_held",  KEY_HELD,  1'b1);
        step(1);
        chk("k6_valid_drop", KEY_VALID, 1'b0);
        step(15);
        chk("k6_one_strobe", strobes, s0 + 1);
        chk("k6_row_fixed",  ROW,     4'b1101);
        pressed[6] = 1'b0;
        step(3);
        chk("k6_held_rel3", KEY_HELD, 1'b1);
        step(1);
        chk("k6_held_rel4", KEY_HELD, 1'b0);
        chk("k6_row_adv",   ROW,      4'b1011);
        step(1);
        chk("k6_scan_resume", ROW, 4'b0111);

        // 3. bouncy press: 2 low, 1 high, then steady low
        wait_row(4'b1101);
        s0 = strobes;
        pressed[6] = 1'b1;
        step(2);
        pressed[6] = 1'b0;
        step(1);
        chk("bnc_same_row", ROW, 4'b1101);
        pressed[6] = 1'b1;
        step(3);
        chk("bnc_no_strobe", strobes, s0);
        step(1);
        chk("bnc_valid", KEY_VALID, 1'b1);
        chk("bnc_count", strobes,   s0 + 1);
        pressed[6] = 1'b0;
        step(5);
        chk("bnc_released", KEY_HELD, 1'b0);

        // 4. no rollover: key 0 held, key 15 ignored until 0 releases
        wait_row(4'b1110);
        pressed[0] = 1'b1;
        s0 = strobes;
        step(4);
        chk("k0_valid", KEY_VALID, 1'b1);
        chk("k0_key",   KEY,       4'h0);
        pressed[15] = 1'b1;
        step(12);
        chk("k15_ignored", strobes,  s0 + 1);
        chk("k0_still",    KEY_HELD, 1'b1);
        pressed[0] = 1'b0;
        step(4);
        chk("k0_released", KEY_HELD, 1'b0);
        wait_strobe(s0 + 1, 20);
        chk("k15_key", KEY, 4'hF);
        pressed[15] = 1'b0;
        step(6);

        // 5a. reset during DEBOUNCE
        wait_row(4'b1101);
        pressed[6] = 1'b1;
        s0 = strobes;
        step(2);
        reset = 1'b0;
        #1;
        chk("rdb_row",   ROW,       4'b1110);
        chk("rdb_key",   KEY,       4'h0);
        chk("rdb_valid", KEY_VALID, 1'b0);
        chk("rdb_held",  KEY_HELD,  1'b0);
        step(2);
        chk("rdb_no_strobe", strobes, s0);
        pressed[6] = 1'b0;
        reset = 1'b1;
        step(2);

        // 5b. reset during HELD, then re-detect the still-held key
        wait_row(4'b1101);
        pressed[6] = 1'b1;
        step(6);
        s1 = strobes;
        chk("rhd_accepted", KEY_HELD, 1'b1);
        reset = 1'b0;
        #1;
        chk("rhd_key",  KEY,      4'h0);
        chk("rhd_held", KEY_HELD, 1'b0);
        chk("rhd_row",  ROW,      4'b1110);
        step(3);
        chk("rhd_no_strobe", strobes, s1);
        reset = 1'b1;
        wait_strobe(s1, 20);
        chk("rhd_redetect_key", KEY, 4'h6);
        pressed[6] = 1'b0;
        step(6);

        // 6. key 9 held ~60 cycles: auto-repeat when enabled, single strobe otherwise
        wait_row(4'b1011);
        n0 = stamp.size();
        pressed[9] = 1'b1;
        step(64);
        nrep = stamp.size() - n0;
`ifdef KEYPAD_REPEAT_EN
        chk("rep_count", nrep, 5);
        if (nrep == 5)
            for (int i = 1; i < 5; i++)
                chk("rep_offset", stamp[n0+i] - stamp[n0], 32 + 8 * (i - 1));
`else
        chk("norep_count", nrep, 1);
`endif
        chk("k9_key", KEY, 4'h9);
        pressed[9] = 1'b0;
        step(6);
        chk("k9_released", KEY_HELD, 1'b0);
        chk("no_double_strobe", doubles, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
